// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with 16x oversampling feeding a FIFO.
// Latency: the byte is pushed 1 clk after the stop-bit mid sample; out_valid rises 2 clk after it when the FIFO was empty.
// Backpressure: valid/ready on the output; a byte arriving while the FIFO is full and not being popped is dropped with overrun_err.
module uart_rx_fifo #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rxd,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     frame_err,
    output logic                     overrun_err,
    output logic                     parity_err
);

    // Oversample tick period, rounded to the nearest whole clock.
    localparam int DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    // ---------------------------------------------------------------
    // Receiver state
    // ---------------------------------------------------------------
    logic          rx_meta_q;
    logic          rx_s_q;
    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic          restart_tick;
    logic [3:0]    sub_q, sub_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_q, push_d;
    logic          frame_err_q, frame_err_d;
    logic          parity_err_q, parity_err_d;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d;
`endif

    // ---------------------------------------------------------------
    // FIFO state
    // ---------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_next;
    logic [LW-1:0] count_q, count_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          overrun_q, overrun_d;
    logic          fifo_full;
    logic          do_pop;
    logic          do_push;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Oversample tick divider; restarted on the start edge so sampling is centred on the bits.
    always_comb begin
        tick       = (tick_cnt_q == TW'(DIV - 1));
        tick_cnt_d = (restart_tick || tick) ? '0 : tick_cnt_q + TW'(1);
    end

    // Receiver FSM state register and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            sub_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            push_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            sub_q        <= sub_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            push_q       <= push_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
`endif
        end
    end

    // Receiver FSM next state: start validation at sub 7, later bits sampled every 16 ticks (sub 15).
    always_comb begin
        state_d      = state_q;
        sub_d        = sub_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        push_d       = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        restart_tick = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d      = S_START;
                    sub_d        = '0;
                    restart_tick = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    if (sub_q == 4'd7) begin
                        if (rx_s_q) begin
                            // Too short to be a start bit: treat as noise.
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                            sub_d   = '0;
                            bit_d   = '0;
                        end
                    end else begin
                        sub_d = sub_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    sub_d = sub_q + 4'd1;
                    if (sub_q == 4'd15) begin
                        shift_d = {rx_s_q, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    sub_d = sub_q + 4'd1;
                    if (sub_q == 4'd15) begin
                        // Even parity: the received bit must equal the XOR of the data bits.
                        par_bad_d = (rx_s_q != ^shift_q);
                        state_d   = S_STOP;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    sub_d = sub_q + 4'd1;
                    if (sub_q == 4'd15) begin
                        if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
                            push_d       = !par_bad_q;
                            parity_err_d = par_bad_q;
`else
                            push_d       = 1'b1;
`endif
                            state_d = S_IDLE;
                        end else begin
                            // Framing error wins over parity; line may be in break.
                            frame_err_d = 1'b1;
                            state_d     = S_BREAK;
                        end
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO control: push/pop qualification, overrun detection and head-register update.
    always_comb begin
        fifo_full  = (count_q == LW'(DEPTH));
        do_pop     = (count_q != '0) && out_ready;
        do_push    = push_q && (!fifo_full || do_pop);
        overrun_d  = push_q && fifo_full && !do_pop;
        rd_next    = rd_ptr_q + AW'(1);
        wr_ptr_d   = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = do_pop ? rd_next : rd_ptr_q;
        out_data_d = out_data_q;
        count_d    = count_q;
        if (do_push && (count_q == '0 || (do_pop && count_q == LW'(1)))) begin
            // Empty, or the only entry leaves now: the new byte becomes the head.
            out_data_d = shift_q;
        end else if (do_pop && count_q > LW'(1)) begin
            out_data_d = mem_q[rd_next];
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset since the head register masks them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // FIFO pointers, occupancy, head register and overrun pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_data_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
            overrun_q  <= overrun_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = (count_q != '0);
    assign fifo_level  = count_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
    assign parity_err  = parity_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of single frames plus glitch, break, overrun, reset and parity sequences.
// Runs with a clock of 64x baud so one oversample tick is 4 clocks.
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int BAUD   = 115200;
    localparam int DIV    = 4;
    localparam int CLK_HZ = BAUD * 16 * DIV;
    localparam int DEPTH  = 16;
    localparam int BITC   = 16 * DIV;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_EDGE = 2 + 168 * DIV;
`else
    localparam int STOP_EDGE = 2 + 152 * DIV;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] fifo_level;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;

    int tests = 0;
    int fails = 0;

    int n_fe = 0;
    int n_oe = 0;
    int n_pe = 0;
    int n_vcyc = 0;
    logic [7:0] popped[$];

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .rxd         (rxd),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fifo_level  (fifo_level),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    // Output monitor: counts pulse cycles and records every accepted byte.
    always @(negedge clk) begin
        if (frame_err === 1'b1)   n_fe++;
        if (overrun_err === 1'b1) n_oe++;
        if (parity_err === 1'b1)  n_pe++;
        if (out_valid === 1'b1)   n_vcyc++;
        if (out_valid === 1'b1 && out_ready === 1'b1) popped.push_back(out_data);
    end

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         exp_pops;
        int         exp_fe;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_bit);
        rxd = 1'b0;
        cyc(BITC);
        for (int k = 0; k < 8; k++) begin
            rxd = b[k];
            cyc(BITC);
        end
`ifdef UART_RX_PARITY_EN
        rxd = par_bit;
        cyc(BITC);
`endif
        rxd = stop_bit;
        cyc(BITC);
    endtask

    initial begin
        int p0, fe0, oe0, pe0, v0;

        vecs[0] = '{data: 8'hA5, stop_ok: 1'b1, exp_pops: 1, exp_fe: 0};
        vecs[1] = '{data: 8'h00, stop_ok: 1'b1, exp_pops: 1, exp_fe: 0};
        vecs[2] = '{data: 8'hFF, stop_ok: 1'b1, exp_pops: 1, exp_fe: 0};
        vecs[3] = '{data: 8'h5A, stop_ok: 1'b1, exp_pops: 1, exp_fe: 0};
        vecs[4] = '{data: 8'h80, stop_ok: 1'b0, exp_pops: 0, exp_fe: 1};
        vecs[5] = '{data: 8'h01, stop_ok: 1'b1, exp_pops: 1, exp_fe: 0};

        reset     = 1'b1;
        rxd       = 1'b1;
        out_ready = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(2);
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_level", fifo_level, 0);
        check("reset_errs", n_fe + n_oe + n_pe, 0);

        // Single frames with the consumer always ready.
        for (int i = 0; i < 6; i++) begin
            p0 = popped.size(); fe0 = n_fe; oe0 = n_oe; pe0 = n_pe; v0 = n_vcyc;
            send_frame(vecs[i].data, vecs[i].stop_ok, ^vecs[i].data);
            rxd = 1'b1;
            cyc(40);
            check("vec_pops", popped.size() - p0, vecs[i].exp_pops);
            check("vec_valid_cycles", n_vcyc - v0, vecs[i].exp_pops);
            if (vecs[i].exp_pops == 1) check("vec_byte", popped[popped.size() - 1], vecs[i].data);
            check("vec_frame_err", n_fe - fe0, vecs[i].exp_fe);
            check("vec_other_errs", (n_oe - oe0) + (n_pe - pe0), 0);
            check("vec_level", fifo_level, 0);
        end

        // Start-bit glitch of 3 ticks.
        p0 = popped.size(); fe0 = n_fe; oe0 = n_oe; pe0 = n_pe;
        rxd = 1'b0;
        cyc(3 * DIV);
        rxd = 1'b1;
        cyc(2 * BITC);
        check("glitch_pops", popped.size() - p0, 0);
        check("glitch_errs", (n_fe - fe0) + (n_oe - oe0) + (n_pe - pe0), 0);
        check("glitch_level", fifo_level, 0);

        // Bad stop bit followed by a held-low line, then a good frame.
        p0 = popped.size(); fe0 = n_fe;
        send_frame(8'h3C, 1'b0, ^8'h3C);
        rxd = 1'b0;
        cyc(20 * BITC);
        rxd = 1'b1;
        cyc(BITC);
        send_frame(8'h55, 1'b1, ^8'h55);
        cyc(40);
        check("break_frame_err", n_fe - fe0, 1);
        check("break_pops", popped.size() - p0, 1);
        check("break_next_byte", popped[popped.size() - 1], 8'h55);

        // Overrun: 17 bytes into a 16-entry FIFO with no consumer.
        out_ready = 1'b0;
        oe0 = n_oe;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, ^(8'(i)));
            cyc(8);
        end
        cyc(40);
        check("ovr_level", fifo_level, 16);
        check("ovr_count", n_oe - oe0, 1);
        check("ovr_head", out_data, 8'h00);
        check("ovr_valid", out_valid, 1);
        p0 = popped.size();
        out_ready = 1'b1;
        cyc(24);
        check("drain_count", popped.size() - p0, 16);
        for (int i = 0; i < 16; i++) check("drain_order", popped[p0 + i], i);
        check("drain_level", fifo_level, 0);
        check("drain_valid", out_valid, 0);
        check("drain_hold_data", out_data, 8'h0F);

        // Full FIFO, consumer pulses ready in the push cycle of one more byte.
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_frame(8'h20 + 8'(i), 1'b1, ^(8'h20 + 8'(i)));
            cyc(8);
        end
        cyc(40);
        check("full_level", fifo_level, 16);
        p0 = popped.size(); oe0 = n_oe;
        fork
            send_frame(8'h30, 1'b1, ^8'h30);
            begin
                cyc(STOP_EDGE);
                out_ready = 1'b1;
                cyc(1);
                out_ready = 1'b0;
            end
        join
        cyc(40);
        check("pp_full_overrun", n_oe - oe0, 0);
        check("pp_full_level", fifo_level, 16);
        check("pp_full_popped", popped.size() - p0, 1);
        check("pp_full_popped_byte", popped[popped.size() - 1], 8'h20);
        check("pp_full_head", out_data, 8'h21);

        // Reset in the middle of a frame's data bits.
        fe0 = n_fe; oe0 = n_oe; pe0 = n_pe;
        rxd = 1'b0;
        cyc(BITC);
        rxd = 1'b1;
        cyc(BITC);
        rxd = 1'b0;
        cyc(BITC / 2);
        reset = 1'b1;
        cyc(2);
        rxd = 1'b1;
        reset = 1'b0;
        cyc(2 * BITC);
        check("midrst_level", fifo_level, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);
        check("midrst_errs", (n_fe - fe0) + (n_oe - oe0) + (n_pe - pe0), 0);
        out_ready = 1'b1;
        p0 = popped.size();
        send_frame(8'h81, 1'b1, ^8'h81);
        cyc(40);
        check("midrst_next_pops", popped.size() - p0, 1);
        check("midrst_next_byte", popped[popped.size() - 1], 8'h81);

`ifdef UART_RX_PARITY_EN
        // Wrong then right parity on 0x07 (three ones: even parity bit is 1).
        p0 = popped.size(); pe0 = n_pe; fe0 = n_fe;
        send_frame(8'h07, 1'b1, 1'b0);
        cyc(40);
        check("par_bad_pulse", n_pe - pe0, 1);
        check("par_bad_pops", popped.size() - p0, 0);
        check("par_bad_fe", n_fe - fe0, 0);
        pe0 = n_pe;
        send_frame(8'h07, 1'b1, 1'b1);
        cyc(40);
        check("par_ok_pulse", n_pe - pe0, 0);
        check("par_ok_pops", popped.size() - p0, 1);
        check("par_ok_byte", popped[popped.size() - 1], 8'h07);
`else
        check("parity_tied_low", n_pe, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
